game_sequencer: RTL

GAME_SEQUENCER -- requirements
Module: game_sequencer

---
 rtl/game_sequencer_pkg.sv | 46 ++++
 rtl/game_sequencer_btn_conditioner.sv | 37 +++
 rtl/game_sequencer.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/game_sequencer_pkg.sv
// Shared grid constants, state encoding and coordinate helpers
// for the battleship-style game sequencer.
package game_sequencer_pkg;

  localparam logic [2:0] ROWS  = 3'd7;
  localparam logic [2:0] COLS  = 3'd5;
  localparam int         CELLS = 35;

  typedef enum logic [2:0] {
    ST_OFF     = 3'd0,
    ST_READY   = 3'd1,
    ST_PLAY    = 3'd2,
    ST_RESOLVE = 3'd3,
    ST_WIN     = 3'd4,
    ST_LOSE    = 3'd5
  } state_e;

  function automatic logic coord_valid(
    input logic [2:0] letter,
    input logic [2:0] number
  );
    return (letter != 3'd0) && (letter <= ROWS) &&
           (number != 3'd0) && (number <= COLS);
  endfunction

  function automatic logic [5:0] coord_idx(
    input logic [2:0] letter,
    input logic [2:0] number
  );
    logic [5:0] l;
    logic [5:0] n;
    l = {3'b000, letter} - 6'd1;
    n = {3'b000, number} - 6'd1;
    return l * 6'd5 + n;
  endfunction

  function automatic int unsigned popcount(
    input logic [CELLS-1:0] v
  );
    int unsigned c;
    c = 0;
    for (int i = 0; i < CELLS; i++) c += 32'(v[i]);
    return c;
  endfunction

endpackage

// File: rtl/game_sequencer_btn_conditioner.sv
// Button conditioner: 2-flop synchronizer, stable-high debounce
// and a single press pulse per accepted press.
module btn_conditioner #(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_btn,
  output logic o_press
);

  logic        r_meta;
  logic        r_sync;
  logic [15:0] r_cnt;
  logic        r_press;

  // Counter saturates once the press is accepted; release re-arms it
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta  <= 1'b0;
      r_sync  <= 1'b0;
      r_cnt   <= 16'd0;
      r_press <= 1'b0;
    end else begin
      r_meta  <= i_btn;
      r_sync  <= r_meta;
      r_press <= r_sync && (r_cnt == DEBOUNCE_CYCLES - 16'd1);
      if (!r_sync)
        r_cnt <= 16'd0;
      else if (r_cnt != DEBOUNCE_CYCLES)
        r_cnt <= r_cnt + 16'd1;
    end
  end

  assign o_press = r_press;

endmodule

// File: rtl/game_sequencer.sv
// Game sequencer: switch-selected shots against a fixed ship map,
// with shot budget, hit tally and win/lose detection.
module game_sequencer
  import game_sequencer_pkg::*;
#(
  parameter int               MAX_SHOTS       = 20,
  parameter logic [CELLS-1:0] SHIP_MAP        = 35'h0_0F0_3C07,
  parameter logic [15:0]      DEBOUNCE_CYCLES = 16'd50000
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [7:0] SW,
  input  logic       BTN_FIRE,
  input  logic       BTN_NEW,
  output logic [2:0] STATE,
  output logic [4:0] SHOTS_LEFT,
  output logic [5:0] HITS,
  output logic       HIT_PULSE,
  output logic       MISS_PULSE,
  output logic       REJECT_PULSE,
  output logic       FIRE_READY,
  output logic       GAME_OVER
);

  localparam logic [4:0] SHOTS_INIT = 5'(MAX_SHOTS);
  localparam logic [5:0] HITS_MAX   = 6'(popcount(SHIP_MAP));

  logic [7:0]       r_sw_meta;
  logic [7:0]       r_sw;
  state_e           r_state;
  state_e           w_next;
  logic [CELLS-1:0] r_fired;
  logic [4:0]       r_shots;
  logic [5:0]       r_hits;
  logic             r_taken;
  logic [5:0]       r_idx;
  logic             r_hit;
  logic             r_miss;
  logic             r_rej;
  logic             r_fire_ready;

  logic             w_fire_p;
  logic             w_new_p;
  logic             w_power;
  logic             w_play;
  logic [2:0]       w_letter;
  logic [2:0]       w_number;
  logic             w_valid;
  logic [5:0]       w_idx;
  logic             w_open;
  logic             w_fire;
  logic             w_shoot;
  logic             w_reject;
  logic             w_new_ok;
  logic             w_resolve;
  logic             w_clear;
  logic [CELLS-1:0] w_fired_nxt;
  logic             w_win;
  logic             w_last;

  btn_conditioner #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_fire (
    .i_clk  (CLK),
    .i_rst_n(RST_N),
    .i_btn  (BTN_FIRE),
    .o_press(w_fire_p)
  );

  btn_conditioner #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_new (
    .i_clk  (CLK),
    .i_rst_n(RST_N),
    .i_btn  (BTN_NEW),
    .o_press(w_new_p)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_sw_meta <= 8'd0;
      r_sw      <= 8'd0;
    end else begin
      r_sw_meta <= SW;
      r_sw      <= r_sw_meta;
    end
  end

  assign w_power  = r_sw[0];
  assign w_play   = r_sw[1];
  assign w_letter = r_sw[7:5];
  assign w_number = r_sw[4:2];
  assign w_valid  = coord_valid(w_letter, w_number);
  assign w_idx    = coord_idx(w_letter, w_number);
  assign w_open   = w_valid && !r_fired[w_idx];

  // A coinciding NEW press always blocks the shot
  assign w_fire   = w_fire_p && !w_new_p && w_power &&
                    w_play && (r_state == ST_PLAY);
  assign w_shoot  = w_fire && w_open;
  assign w_reject = w_fire && !w_open;

  assign w_new_ok = w_new_p && w_power &&
                    ((r_state == ST_READY) ||
                     (r_state == ST_WIN) ||
                     (r_state == ST_LOSE) ||
                     ((r_state == ST_PLAY) && !r_taken));

  assign w_resolve   = w_power && (r_state == ST_RESOLVE);
  assign w_clear     = !w_power || (r_state == ST_OFF) || w_new_ok;
  assign w_fired_nxt = r_fired | (35'd1 << r_idx);
  assign w_win       = (w_fired_nxt & SHIP_MAP) == SHIP_MAP;
  assign w_last      = r_shots <= 5'd1;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) r_state <= ST_OFF;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (!w_power) begin
      w_next = ST_OFF;
    end else if (w_new_ok) begin
      w_next = ST_READY;
    end else begin
      unique case (r_state)
        ST_OFF:     w_next = ST_READY;
        ST_READY:   if (w_play) w_next = ST_PLAY;
        ST_PLAY:    if (w_shoot) w_next = ST_RESOLVE;
        ST_RESOLVE: w_next = w_win  ? ST_WIN  :
                             w_last ? ST_LOSE : ST_PLAY;
        default:    w_next = r_state;
      endcase
    end
  end

  always_comb begin
    STATE        = r_state;
    GAME_OVER    = (r_state == ST_WIN) || (r_state == ST_LOSE);
    SHOTS_LEFT   = r_shots;
    HITS         = r_hits;
    HIT_PULSE    = r_hit;
    MISS_PULSE   = r_miss;
    REJECT_PULSE = r_rej;
    FIRE_READY   = r_fire_ready;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_fired      <= '0;
      r_shots      <= SHOTS_INIT;
      r_hits       <= 6'd0;
      r_taken      <= 1'b0;
      r_idx        <= 6'd0;
      r_hit        <= 1'b0;
      r_miss       <= 1'b0;
      r_rej        <= 1'b0;
      r_fire_ready <= 1'b0;
    end else begin
      r_hit        <= 1'b0;
      r_miss       <= 1'b0;
      r_rej        <= w_reject;
      r_fire_ready <= (r_state == ST_PLAY) && w_play && w_open;
      if (w_shoot) r_idx <= w_idx;
      if (w_clear) begin
        r_fired <= '0;
        r_shots <= SHOTS_INIT;
        r_hits  <= 6'd0;
        r_taken <= 1'b0;
      end else if (w_resolve) begin
        r_fired <= w_fired_nxt;
        r_taken <= 1'b1;
        if (r_shots != 5'd0) r_shots <= r_shots - 5'd1;
        if (SHIP_MAP[r_idx]) begin
          r_hit <= 1'b1;
          if (r_hits != HITS_MAX) r_hits <= r_hits + 6'd1;
        end else begin
          r_miss <= 1'b1;
        end
      end
    end
  end

endmodule
